// File: rtl/sample_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sample_fifo                                                 |
// | Purpose  : Single-clock FIFO for DW-bit samples with registered read   |
// |            data, occupancy count, full/empty decode, and sticky        |
// |            overflow/underflow flags.                                   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module sample_fifo #(
  parameter int  DW    = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  // Storage array; deliberately left out of reset.
  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [AW:0]   count_q,     count_d;
  logic [DW-1:0] rd_data_q,   rd_data_d;
  logic          rd_valid_q,  rd_valid_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic          wr_acc;
  logic          rd_acc;
  logic          full_w;
  logic          empty_w;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // Accept decisions use pre-edge state; a read frees a slot for a write to a full FIFO.
  always_comb begin
    wr_acc = wr_en & (~full_w | rd_en);
    rd_acc = rd_en & ~empty_w;
  end

  // Next-state for pointers, occupancy, read data and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    count_d     = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    if (wr_en & full_w & ~rd_en) begin
      overflow_d = 1'b1;
    end
    if (rd_en & empty_w) begin
      underflow_d = 1'b1;
    end
  end

  // Control and status registers; reset asserts without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write; a same-edge read of this slot still sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sample_fifo                                              |
// | Purpose  : Self-checking bench for sample_fifo using a reference       |
// |            queue model and an expected-output scoreboard.              |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_sample_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  bit         vld_q[$];
  bit         ovf_m;
  bit         unf_m;

  sample_fifo #(.DW(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each posedge, compare rd_valid and popped data against predictions.
  always @(posedge clk) begin
    bit         ev;
    logic [7:0] ed;
    #1;
    ev = 1'b0;
    if (vld_q.size() > 0) ev = vld_q.pop_front();
    checks++;
    if (rd_valid !== ev) begin
      errors++;
      $display("FAIL rd_valid: got %b expected %b at %0t", rd_valid, ev, $time);
    end
    if (ev) begin
      ed = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (rd_data !== ed) begin
        errors++;
        $display("FAIL rd_data: got %h expected %h at %0t", rd_data, ed, $time);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

  // One clock of stimulus; updates the reference model and scoreboard.
  task automatic cycle(input bit we, input logic [7:0] wd, input bit re);
    bit fm, em, wacc, racc;
    @(negedge clk);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    fm   = (model.size() == 4);
    em   = (model.size() == 0);
    wacc = we && (!fm || re);
    racc = re && !em;
    if (we && fm && !re) ovf_m = 1'b1;
    if (re && em)        unf_m = 1'b1;
    if (racc) exp_q.push_back(model.pop_front());
    vld_q.push_back(racc);
    if (wacc) model.push_back(wd);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    model.delete();
    exp_q.delete();
    vld_q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 ||
        rd_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d e=%b f=%b v=%b d=%h o=%b u=%b expected 0 1 0 0 00 0 0",
               count, empty, full, rd_valid, rd_data, overflow, underflow);
    end
    // Move pointers away from zero, then reset asynchronously with a write pending.
    cycle(1, 8'hC1, 0);
    cycle(1, 8'hC2, 0);
    cycle(0, 8'h00, 1);
    cycle(1, 8'hC3, 1);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    rd_en   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d e=%b f=%b v=%b o=%b u=%b expected 0 1 0 0 0 0",
               count, empty, full, rd_valid, overflow, underflow);
    end
    model.delete();
    exp_q.delete();
    vld_q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    cycle(1, 8'hA5, 0);
    checks++;
    if (dut.mem_q[0] !== 8'hA5 || count !== 3'd1) begin
      errors++;
      $display("FAIL first_write_entry0: mem0=%h cnt=%0d expected a5 1", dut.mem_q[0], count);
    end
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h0A; vals[1] = 8'h14; vals[2] = 8'h1E; vals[3] = 8'h28;
    for (int i = 0; i < 4; i++) begin
      cycle(1, vals[i], 0);
      checks++;
      if (count !== 3'(i + 1) || full !== (i == 3)) begin
        errors++;
        $display("FAIL fill_count: cnt=%0d full=%b expected %0d %b", count, full, i + 1, (i == 3));
      end
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1);
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b cnt=%0d expected 1 0", empty, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) cycle(1, 8'(10 * (i + 1)), 0);
    cycle(1, 8'h55, 0);
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || overflow !== ovf_m) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b cnt=%0d expected 1 4", overflow, count);
    end
    cycle(0, 8'h00, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b expected 1", overflow);
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain: empty=%b unf=%b expected 1 0", empty, underflow);
    end
  endtask

  task automatic test_underflow_simul();
    cycle(1, 8'h33, 1);
    checks++;
    if (count !== 3'd1 || underflow !== 1'b1 || rd_valid !== 1'b0 || underflow !== unf_m) begin
      errors++;
      $display("FAIL empty_wr_rd: cnt=%0d unf=%b v=%b expected 1 1 0", count, underflow, rd_valid);
    end
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    checks++;
    if (underflow !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: unf=%b empty=%b expected 1 1", underflow, empty);
    end
  endtask

  task automatic test_full_simul();
    cycle(1, 8'h11, 0);
    cycle(1, 8'h22, 0);
    cycle(1, 8'h33, 0);
    cycle(1, 8'h44, 0);
    cycle(1, 8'h77, 1);
    checks++;
    if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_wr_rd: cnt=%0d ovf=%b full=%b expected 4 0 1", count, overflow, full);
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
  endtask

  task automatic test_streaming();
    cycle(1, 8'hF0, 0);
    cycle(1, 8'hF1, 0);
    for (int i = 1; i <= 20; i++) begin
      cycle(1, 8'(i), 1);
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL stream_count: cnt=%0d expected 2 at step %0d", count, i);
      end
    end
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: empty=%b ovf=%b unf=%b expected 1 0 0", empty, overflow, underflow);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    ovf_m   = 1'b0;
    unf_m   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    apply_reset();
    test_underflow_simul();
    apply_reset();
    test_full_simul();
    test_streaming();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || vld_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d data / %0d valid entries left, expected 0",
               exp_q.size(), vld_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
